// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit
// positions, FSM encodings and the divisor floor.
package uart_pkg;

    localparam logic [1:0] UART_DATA   = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_DIV    = 2'd2;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_VALID  = 2;
    localparam int ST_RX_OVR    = 3;
    localparam int ST_TX_BUSY   = 4;
    localparam int ST_FRAME_ERR = 5;

    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_bus_sync_fifo.sv
// Byte FIFO with first-word-fall-through head; push and pop are judged on the
// pre-update occupancy, so a push into a full FIFO is dropped even if it pops.
module sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (int'(count) == DEPTH);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_bus.sv
// Memory-mapped UART: single-cycle stb/ack bus slave with TX/RX byte FIFOs,
// STATUS and DIVISOR registers, and 8N1 serial transmit/receive engines.
module uart_bus
    import uart_pkg::*;
#(
    parameter int DEFAULT_DIV = 434,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_dat_w,
    input  logic [3:0]  i_we,
    input  logic        i_stb,
    output logic [31:0] o_dat_r,
    output logic        o_ack,
    output logic        o_tx,
    input  logic        i_rx
);

    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

    logic        vld_p0;
    logic [1:0]  addr_p0;
    logic [1:0]  we_p0;
    logic        rd_p0;
    logic [15:0] dat_p0;
    logic        accept;
    logic        unused_bits;

    logic        wr_data, rd_data, wr_status, wr_div;
    logic [15:0] divisor, div_merged;
    logic        rx_ovr, frame_err, clr_ovr, clr_ferr;
    logic [31:0] rdata;

    logic        tx_full, tx_empty, tx_pop;
    logic [7:0]  tx_head;
    tx_state_t   tx_state, tx_next;
    logic [15:0] tx_cnt, tx_div;
    logic [2:0]  tx_idx;
    logic [7:0]  tx_shreg;
    logic        tx_bit_end;

    logic        rx_full, rx_empty, rx_push;
    logic [7:0]  rx_head;
    rx_state_t   rx_state, rx_next;
    logic [15:0] rx_cnt, rx_div;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shreg;
    logic        rx_meta, rx_sync, rx_prev;
    logic        rx_fall, rx_mid, rx_bit_end;
    logic        ovr_set, ferr_set;

    assign unused_bits = ^{i_addr[31:4], i_addr[1:0], i_dat_w[31:16]};

    // Request stage: a strobe is captured here and answered in the next cycle
    assign accept = i_stb && !vld_p0;

    always_ff @(posedge i_clk) begin
        if (i_rst) vld_p0 <= 1'b0;
        else       vld_p0 <= accept;
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            addr_p0 <= i_addr[3:2];
            we_p0   <= i_we[1:0];
            rd_p0   <= (i_we == 4'b0000);
            dat_p0  <= i_dat_w[15:0];
        end
    end

    // Ack stage: side effects commit at the end of the ack cycle
    assign o_ack     = vld_p0;
    assign wr_data   = vld_p0 && (addr_p0 == UART_DATA) && we_p0[0];
    assign rd_data   = vld_p0 && (addr_p0 == UART_DATA) && rd_p0;
    assign wr_status = vld_p0 && (addr_p0 == UART_STATUS) && we_p0[0];
    assign wr_div    = vld_p0 && (addr_p0 == UART_DIV) && (we_p0 != 2'b00);
    assign clr_ovr   = wr_status && dat_p0[ST_RX_OVR];
    assign clr_ferr  = wr_status && dat_p0[ST_FRAME_ERR];

    assign div_merged = {we_p0[1] ? dat_p0[15:8] : divisor[15:8],
                         we_p0[0] ? dat_p0[7:0]  : divisor[7:0]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            divisor   <= 16'(DEFAULT_DIV);
            rx_ovr    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr_div) divisor <= clamp_div(div_merged);
            if (ovr_set)      rx_ovr <= 1'b1;
            else if (clr_ovr) rx_ovr <= 1'b0;
            if (ferr_set)      frame_err <= 1'b1;
            else if (clr_ferr) frame_err <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (vld_p0) begin
            case (addr_p0)
                UART_DATA:   rdata = {24'h0, rx_empty ? 8'h00 : rx_head};
                UART_STATUS: begin
                    rdata[ST_TX_FULL]   = tx_full;
                    rdata[ST_TX_EMPTY]  = tx_empty;
                    rdata[ST_RX_VALID]  = !rx_empty;
                    rdata[ST_RX_OVR]    = rx_ovr;
                    rdata[ST_TX_BUSY]   = (tx_state != TX_IDLE) || !tx_empty;
                    rdata[ST_FRAME_ERR] = frame_err;
                end
                UART_DIV:    rdata = {16'h0, divisor};
                default:     rdata = '0;
            endcase
        end
    end
    assign o_dat_r = rdata;

    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk(i_clk), .i_rst(i_rst), .push(wr_data), .din(dat_p0[7:0]),
        .pop(tx_pop), .full(tx_full), .empty(tx_empty), .head(tx_head)
    );

    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk(i_clk), .i_rst(i_rst), .push(rx_push), .din(rx_shreg),
        .pop(rd_data), .full(rx_full), .empty(rx_empty), .head(rx_head)
    );

    // Transmitter: the STOP bit chains straight into the next START when queued
    always_comb begin
        tx_next    = tx_state;
        tx_pop     = 1'b0;
        tx_bit_end = (tx_cnt == tx_div - 16'd1);
        case (tx_state)
            TX_IDLE:  if (!tx_empty) begin
                          tx_pop  = 1'b1;
                          tx_next = TX_START;
                      end
            TX_START: if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_bit_end) begin
                          if (!tx_empty) begin
                              tx_pop  = 1'b1;
                              tx_next = TX_START;
                          end else begin
                              tx_next = TX_IDLE;
                          end
                      end
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_div   <= 16'(DEFAULT_DIV);
        end else begin
            tx_state <= tx_next;
            if (tx_pop || (tx_state != TX_IDLE && tx_bit_end)) begin
                tx_cnt <= '0;
                tx_div <= divisor;
            end else if (tx_state != TX_IDLE) begin
                tx_cnt <= tx_cnt + 16'd1;
            end
            if (tx_state == TX_START)                  tx_idx <= 3'd0;
            else if (tx_state == TX_DATA && tx_bit_end) tx_idx <= tx_idx + 3'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (tx_pop)                                 tx_shreg <= tx_head;
        else if (tx_state == TX_DATA && tx_bit_end) tx_shreg <= {1'b0, tx_shreg[7:1]};
    end

    assign o_tx = (tx_state == TX_START) ? 1'b0 :
                  (tx_state == TX_DATA)  ? tx_shreg[0] : 1'b1;

    // Receiver: START samples mid-bit, later samples are one full bit apart
    always_comb begin
        rx_next    = rx_state;
        rx_push    = 1'b0;
        ovr_set    = 1'b0;
        ferr_set   = 1'b0;
        rx_fall    = rx_prev && !rx_sync;
        rx_mid     = (rx_cnt == (rx_div >> 1));
        rx_bit_end = (rx_cnt == rx_div - 16'd1);
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_mid) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_end && rx_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_bit_end) begin
                          rx_next = RX_IDLE;
                          if (!rx_sync)     ferr_set = 1'b1;
                          else if (rx_full) ovr_set  = 1'b1;
                          else              rx_push  = 1'b1;
                      end
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_div   <= 16'(DEFAULT_DIV);
        end else begin
            rx_meta  <= i_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_next;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_div <= divisor;
                end
                RX_START: begin
                    if (rx_mid) begin
                        rx_cnt <= '0;
                        rx_div <= divisor;
                        rx_idx <= 3'd0;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (rx_bit_end) begin
                        rx_cnt <= '0;
                        rx_div <= divisor;
                        if (rx_state == RX_DATA) rx_idx <= rx_idx + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (rx_state == RX_DATA && rx_bit_end) rx_shreg <= {rx_sync, rx_shreg[7:1]};
    end

endmodule

// File: tb/tb_uart_bus.sv
// Randomized self-checking bench for uart_bus: bus handshake, divisor rules,
// TX/RX framing, FIFO overflow and sticky error bits against a queue model.
module tb_uart_bus;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_addr;
    logic [31:0] i_dat_w;
    logic [3:0]  i_we;
    logic        i_stb;
    logic [31:0] o_dat_r;
    logic        o_ack;
    logic        o_tx;
    logic        i_rx;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int commit_cyc;

    uart_bus #(.DEFAULT_DIV(434), .FIFO_DEPTH(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_dat_w(i_dat_w),
        .i_we(i_we), .i_stb(i_stb), .o_dat_r(o_dat_r), .o_ack(o_ack),
        .o_tx(o_tx), .i_rx(i_rx)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clk(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic bus_xfer(input logic [3:0] off, input logic [3:0] we,
                            input logic [31:0] wdat, output logic [31:0] rdat);
        @(posedge i_clk); #1;
        i_addr  = ($urandom() & 32'hFFFF_FFF0) | {28'h0, off};
        i_we    = we;
        i_dat_w = wdat;
        i_stb   = 1'b1;
        @(posedge i_clk); #1;
        i_stb = 1'b0;
        check_eq("ack_high", {31'h0, o_ack}, 32'h1);
        rdat = o_dat_r;
        @(posedge i_clk); #1;
        commit_cyc = cyc;
        check_eq("ack_low", {31'h0, o_ack}, 32'h0);
        check_eq("rdat_idle", o_dat_r, 32'h0);
    endtask

    task automatic wr(input logic [3:0] off, input logic [3:0] we, input logic [31:0] d);
        logic [31:0] dummy;
        bus_xfer(off, we, d, dummy);
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] d);
        bus_xfer(off, 4'b0000, 32'h0, d);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop, input int div);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            i_rx = frame[i];
            clk(div);
        end
        i_rx = 1'b1;
    endtask

    function automatic int pops_before(input int edge_idx, input int c0, input int per);
        int n = 0;
        for (int k = 0; c0 + 1 + per * k < edge_idx; k++) n++;
        return n;
    endfunction

    logic [31:0] r;
    logic [15:0] div_m, v, merged;
    logic [1:0]  lanes;
    logic [7:0]  b, a5;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  cap_q[$];
    logic        ovr_m;
    int          n;

    initial begin
        i_rst = 1'b1; i_stb = 1'b0; i_we = '0; i_addr = '0; i_dat_w = '0; i_rx = 1'b1;
        clk(2);
        i_rst = 1'b0;
        check_eq("rst_tx", {31'h0, o_tx}, 32'h1);
        check_eq("rst_ack", {31'h0, o_ack}, 32'h0);
        check_eq("rst_dat", o_dat_r, 32'h0);
        rd(4'h4, r); check_eq("rst_status", r, 32'h02);
        rd(4'h8, r); check_eq("rst_div", r, 32'd434);

        wr(4'h8, 4'b0011, 32'h0000_0010);
        rd(4'h8, r); check_eq("div_rw", r, 32'h10);
        wr(4'h8, 4'b0011, 32'h0000_0002);
        rd(4'h8, r); check_eq("div_clamp", r, 32'd4);
        rd(4'hC, r); check_eq("reserved", r, 32'h0);

        div_m = 16'd4;
        for (int i = 0; i < 6; i++) begin
            v     = (i < 2) ? 16'($urandom_range(0, 5)) : 16'($urandom_range(0, 65535));
            lanes = 2'($urandom_range(1, 3));
            merged = {lanes[1] ? v[15:8] : div_m[15:8], lanes[0] ? v[7:0] : div_m[7:0]};
            div_m  = (merged < 16'd4) ? 16'd4 : merged;
            wr(4'h8, {2'($urandom_range(0, 3)), lanes}, {16'($urandom()), v});
            rd(4'h8, r); check_eq("div_rand", r, {16'h0, div_m});
        end

        // TX single frame, 16 clocks per bit
        wr(4'h8, 4'b0011, 32'd16);
        a5 = 8'hA5;
        wr(4'h0, 4'b0001, 32'hFFFF_FFA5);
        check_eq("tx_lat_pre", {31'h0, o_tx}, 32'h1);
        clk(1);
        check_eq("tx_lat", {31'h0, o_tx}, 32'h0);
        for (int bi = 0; bi < 10; bi++) begin
            logic eb;
            eb = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : a5[bi-1];
            n = 0;
            for (int c = 0; c < 16; c++) begin
                if (o_tx === eb) n++;
                clk(1);
            end
            check_eq($sformatf("tx_bit%0d", bi), n, 16);
        end
        rd(4'h4, r); check_eq("tx_idle_status", r, 32'h02);

        // RX: 17 frames into a 16-deep FIFO with no reads
        ovr_m = 1'b0;
        for (int f = 0; f < 17; f++) begin
            b = 8'($urandom());
            rx_send(b, 1'b1, 16);
            if (rx_q.size() < 16) rx_q.push_back(b);
            else                  ovr_m = 1'b1;
        end
        clk(8);
        rd(4'h4, r);
        check_eq("rx_ovr_status", r, 32'h02 | ((rx_q.size() > 0) ? 32'h04 : 32'h0) | {28'h0, ovr_m, 3'b0});
        for (int i = 0; i < 17; i++) begin
            rd(4'h0, r);
            check_eq($sformatf("rx_data%0d", i), r, (rx_q.size() > 0) ? {24'h0, rx_q.pop_front()} : 32'h0);
        end
        rd(4'h4, r); check_eq("rx_drained", r, 32'h0A);
        wr(4'h4, 4'b0001, 32'h08);
        rd(4'h4, r); check_eq("ovr_clear", r, 32'h02);

        // RX glitch, bad stop bit, then recovery
        i_rx = 1'b0; clk(4); i_rx = 1'b1; clk(64);
        rd(4'h4, r); check_eq("glitch", r, 32'h02);
        rx_send(8'h3C, 1'b0, 16);
        clk(32);
        rd(4'h4, r); check_eq("frame_err", r, 32'h22);
        wr(4'h4, 4'b0001, 32'h20);
        rd(4'h4, r); check_eq("ferr_clear", r, 32'h02);
        b = 8'($urandom());
        rx_send(b, 1'b1, 16);
        clk(8);
        rd(4'h0, r); check_eq("rx_recover", r, {24'h0, b});

        // TX overflow with DIVISOR=4: 20 back-to-back writes
        wr(4'h8, 4'b0011, 32'd4);
        fork
            begin
                int c0, occ;
                c0 = 0;
                for (int i = 0; i < 20; i++) begin
                    b = 8'($urandom());
                    wr(4'h0, 4'b0001, {24'h0, b});
                    if (i == 0) c0 = commit_cyc;
                    occ = exp_q.size() - pops_before(commit_cyc, c0, 40);
                    if (occ < 16) exp_q.push_back(b);
                end
                rd(4'h4, r);
                occ = exp_q.size() - pops_before(commit_cyc, c0, 40);
                check_eq("tx_full", {31'h0, r[0]}, {31'h0, occ >= 16});
            end
            begin
                int t;
                logic [7:0] fr;
                logic st, sp;
                for (t = 0; t < 100 && o_tx !== 1'b0; t++) clk(1);
                check_eq("tx_start_seen", {31'h0, o_tx}, 32'h0);
                if (o_tx === 1'b0) begin
                    do begin
                        st = 1'b1; sp = 1'b0; fr = '0;
                        for (int c = 0; c < 40; c++) begin
                            if (c % 4 == 2) begin
                                if (c / 4 == 0)      st = o_tx;
                                else if (c / 4 == 9) sp = o_tx;
                                else                 fr[c/4-1] = o_tx;
                            end
                            clk(1);
                        end
                        check_eq("txo_start", {31'h0, st}, 32'h0);
                        check_eq("txo_stop", {31'h0, sp}, 32'h1);
                        cap_q.push_back(fr);
                    end while (o_tx === 1'b0 && cap_q.size() < 20);
                end
            end
        join
        check_eq("txo_count", cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check_eq($sformatf("txo_byte%0d", i), {24'h0, cap_q[i]}, {24'h0, exp_q[i]});

        // Reset in the middle of a frame
        wr(4'h0, 4'b0001, 32'h00);
        clk(3);
        check_eq("pre_rst_tx", {31'h0, o_tx}, 32'h0);
        i_rst = 1'b1;
        clk(1);
        check_eq("midframe_rst_tx", {31'h0, o_tx}, 32'h1);
        i_rst = 1'b0;
        rd(4'h8, r); check_eq("rst2_div", r, 32'd434);
        rd(4'h4, r); check_eq("rst2_status", r, 32'h02);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_bus.md
# uart_bus

Memory-mapped UART peripheral sitting directly downstream of the or32 core's data/instruction bus. It consumes the core's single-cycle `stb`/`ack` requests, exposes TX/RX byte FIFOs, a status register and a baud divisor, and drives the serial pins. An upstream address decoder gates `i_stb` for this block's 16-byte window, so only `i_addr[3:2]` is decoded here.

## Interface
- `DEFAULT_DIV`, 434: reset value of the divisor, in clocks per bit (50 MHz / 115200).
- `FIFO_DEPTH`, 16: entries per TX/RX FIFO. Must be a power of two and at least 2.
- `i_clk` in 1: clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_addr` in 32: byte address. Only bits [3:2] are decoded.
- `i_dat_w` in 32: write data.
- `i_we` in 4: byte-lane write enables. All zero means a read.
- `i_stb` in 1: request strobe, a one-cycle pulse.
- `o_dat_r` out 32: read data, valid while `o_ack` is high.
- `o_ack` out 1: request completion, a one-cycle pulse.
- `o_tx` out 1: serial transmit line, idle high.
- `i_rx` in 1: serial receive line, asynchronous.

## Operation
Register map (word offsets):
- **0x0 DATA**
  - Write with `i_we[0]`: push `i_dat_w[7:0]` into the TX FIFO. If the FIFO is full, the byte is silently dropped.
  - Read: return `{24'h0, rx_head}` and pop. If the RX FIFO is empty, return 0 and do not pop.
- **0x4 STATUS** (read):
  - bit0 tx_full, bit1 tx_empty, bit2 rx_valid, bit3 rx_overrun (sticky), bit4 tx_busy (shifter active or FIFO non-empty), bit5 frame_err (sticky). Other bits read 0.
  - Write with `i_we[0]`: a 1 in bit3 clears overrun; a 1 in bit5 clears frame_err.
- **0x8 DIVISOR**: R/W `[15:0]`, with lanes `i_we[0]` and `i_we[1]`; upper bits read 0. The stored value is clamped to a minimum of 4 on write. The new value applies at the next bit boundary.
- **0xC**: reserved. Reads 0; writes ignored.

TX FSM:
- States: IDLE → START → DATA → STOP → IDLE.
- IDLE: when the FIFO is non-empty, pop one byte and enter START.
- Each state lasts DIVISOR clocks.
- DATA sends 8 bits, LSB first. STOP drives 1.
- Back-to-back bytes do not insert an idle gap.

RX FSM:
- `i_rx` passes through a 2-FF synchronizer; RX logic sees the synchronized signal only.
- States: IDLE → START → DATA → STOP → IDLE.
- IDLE: a falling edge enters START.
- START: sample at DIVISOR/2.
  - If the sample is high, it is a false start; return to IDLE.
  - Otherwise, sample every DIVISOR clocks thereafter: 8 data bits, then the stop bit.
- Stop = 0: discard the byte, set frame_err.
- Stop = 1 with RX FIFO full: drop the byte, set rx_overrun.
- Stop = 1 otherwise: push the byte.
- Return to IDLE after the stop sample, ready for the next falling edge.

Simultaneous events:
- FIFO push and pop in the same cycle are both performed; the count is unchanged.
- A CPU TX push while full is judged on pre-pop state and is dropped, even if the TX FSM pops in the same cycle.
- RX push while full in the same cycle as a CPU pop is judged on pre-pop state and is dropped, setting overrun.
- A clear of a sticky bit in the same cycle as a new event that sets it: the set wins.

## Timing
- Request accepted in cycle N (`i_stb`=1): `o_ack`=1 in cycle N+1 for exactly one cycle. Read data is valid in N+1; register/FIFO side effects are committed at the N+1 edge.
- `i_stb` while `o_ack` is high cannot occur, because the core issues one outstanding request. If it does occur, it is ignored.
- `o_dat_r` is 0 whenever `o_ack` is 0.
- Reset values:
  - `o_ack`=0, `o_dat_r`=0, `o_tx`=1.
  - Both FIFOs empty, both FSMs IDLE.
  - DIVISOR=`DEFAULT_DIV`; sticky bits cleared.
- Reset mid-frame: `o_tx` returns high the cycle after reset is sampled. A partial RX byte is discarded.
- Bit period is exactly DIVISOR clocks. A frame is 10×DIVISOR clocks.
- TX latency: `o_tx` falls 2 clocks after the ack edge of a DATA write into an empty, idle TX path.
- RX latency: rx_valid sets 3 clocks after the stop-bit sample point (2 synchronizer + 1 push).

## Structure
- Package `uart_pkg`:
  - register offsets (`UART_DATA`=2'd0, `UART_STATUS`=2'd1, `UART_DIV`=2'd2);
  - STATUS bit indices;
  - TX/RX state encodings;
  - `DIV_MIN`=4.
- Sub-module `sync_fifo` (8-bit data, parameter DEPTH; ports push, pop, full, empty, head), instantiated once for TX and once for RX. The FSMs and bus decode stay in `uart_bus`.

## Test plan
- **Reset:** assert `i_rst` for 2 cycles → `o_tx`=1, `o_ack`=0; STATUS reads 0x02; DIVISOR reads 434.
- **Bus handshake:** `i_stb` with `i_addr`=0x8, `i_we`=4'b0011, `i_dat_w`=0x0010 → `o_ack` one cycle later for one cycle; a readback returns 0x00000010. Writing 2 then reading returns 4.
- **TX frame:** DIVISOR=16; write DATA=0xA5 → `o_tx` shows start 0, bits 1,0,1,0,0,1,0,1, then stop 1, each lasting exactly 16 clocks. tx_busy clears after the stop bit.
- **RX with overflow:** drive 17 valid frames into `i_rx` with FIFO_DEPTH=16 and no reads → rx_valid=1, rx_overrun=1. Sixteen DATA reads return bytes in order; a 17th read returns 0.
- **RX errors:** a 0.25-bit low glitch produces no byte. A frame with stop=0 sets frame_err and pushes nothing. Writing STATUS=0x20 clears frame_err.
- **TX overflow:** write 20 bytes back-to-back with DIVISOR=4 → tx_full is observed. Exactly the bytes accepted before full appear on `o_tx`, in order, with no gaps between frames.
